// File: rtl/pc_sequencer.sv
// Program counter owner for the ECAP5-DPROC core: boot, sequential fetch,
// branch redirects, interrupt entry/return and debug entry/return.

package ecap5_dproc_pkg;
  localparam logic [31:0] BOOT_ADDRESS      = 32'h0000_0000;
  localparam logic [31:0] INTERRUPT_ADDRESS = 32'hFF00_000A;
  localparam logic [31:0] DEBUG_ADDRESS     = 32'hFF00_000B;
endpackage

module pc_sequencer
  import ecap5_dproc_pkg::*;
#(
  parameter int unsigned PC_STEP     = 4,
  parameter int unsigned IRQ_ENABLED = 1
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        stall_i,
  input  logic        branch_valid_i,
  input  logic [31:0] branch_target_i,
  input  logic        irq_i,
  input  logic        irq_enable_i,
  input  logic        mret_i,
  input  logic        debug_req_i,
  input  logic        dret_i,
  output logic [31:0] pc_o,
  output logic        pc_valid_o,
  output logic        flush_o,
  output logic [31:0] epc_o,
  output logic [31:0] dpc_o,
  output logic        in_irq_o,
  output logic        in_debug_o
);

  localparam logic [31:0] STEP   = 32'(PC_STEP);
  localparam logic        IRQ_ON = (IRQ_ENABLED != 0);

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DEBUG = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] epc_q, epc_d;
  logic [31:0] dpc_q, dpc_d;
  logic        in_irq_q, in_irq_d;
  logic        flush_q, flush_d;

  logic [31:0] seq_pc;
  logic [31:0] br_pc;
  logic [31:0] next_pc;
  logic        irq_take;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= ST_BOOT;
      pc_q     <= BOOT_ADDRESS;
      epc_q    <= '0;
      dpc_q    <= '0;
      in_irq_q <= 1'b0;
      flush_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      epc_q    <= epc_d;
      dpc_q    <= dpc_d;
      in_irq_q <= in_irq_d;
      flush_q  <= flush_d;
    end
  end

  // next_pc is what would have been fetched had no trap occurred, so a branch
  // losing to an irq/debug entry is resumed through epc/dpc rather than dropped.
  always_comb begin
    seq_pc   = stall_i ? pc_q : pc_q + STEP;
    br_pc    = {branch_target_i[31:2], 2'b00};
    next_pc  = branch_valid_i ? br_pc : seq_pc;
    irq_take = irq_i & irq_enable_i & ~in_irq_q & IRQ_ON;
  end

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    epc_d    = epc_q;
    dpc_d    = dpc_q;
    in_irq_d = in_irq_q;
    flush_d  = 1'b0;

    unique case (state_q)
      ST_BOOT: begin
        state_d = ST_RUN;
      end

      ST_RUN: begin
        if (debug_req_i) begin
          dpc_d   = next_pc;
          pc_d    = DEBUG_ADDRESS;
          flush_d = 1'b1;
          state_d = ST_DEBUG;
        end else if (irq_take) begin
          epc_d    = next_pc;
          pc_d     = INTERRUPT_ADDRESS;
          flush_d  = 1'b1;
          in_irq_d = 1'b1;
        end else if (mret_i && in_irq_q) begin
          pc_d     = epc_q;
          flush_d  = 1'b1;
          in_irq_d = 1'b0;
        end else if (branch_valid_i) begin
          pc_d    = br_pc;
          flush_d = 1'b1;
        end else begin
          pc_d = seq_pc;
        end
      end

      ST_DEBUG: begin
        if (dret_i) begin
          pc_d    = dpc_q;
          flush_d = 1'b1;
          state_d = ST_RUN;
        end else if (branch_valid_i) begin
          pc_d    = br_pc;
          flush_d = 1'b1;
        end else begin
          pc_d = seq_pc;
        end
      end

      default: begin
        state_d = ST_BOOT;
      end
    endcase
  end

  always_comb begin
    pc_o       = pc_q;
    pc_valid_o = (state_q != ST_BOOT);
    flush_o    = flush_q;
    epc_o      = epc_q;
    dpc_o      = dpc_q;
    in_irq_o   = in_irq_q;
    in_debug_o = (state_q == ST_DEBUG);
  end

endmodule
